// File: rtl/result_writeback_if.sv
// Pixel stream and frame-buffer write bus between the result writer and its neighbours.
// pix_*: a beat transfers on a clock edge where pix_valid && pix_ready; write_result is held until wr_done.
interface result_writeback_if;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       pix_ready;
  logic       write_result;
  logic [17:0] address;
  logic [7:0] new_data;
  logic       wr_done;

  modport slave (
    input  pix_valid, pix_data, wr_done,
    output pix_ready, write_result, address, new_data
  );

  modport master (
    output pix_valid, pix_data, wr_done,
    input  pix_ready, write_result, address, new_data
  );
endinterface

// File: rtl/result_writeback.sv
// Buffers filtered pixels in a small FIFO and writes them one by one to consecutive
// frame-buffer byte addresses through the write_result/wr_done handshake.
module result_writeback #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [17:0] base_addr,
  input  logic [17:0] pix_count,
  output logic        busy,
  output logic        finished,
  output logic        error,
  output logic [2:0]  dbg_state,
  result_writeback_if.slave wb
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WRITE   = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4,
    S_ABORT   = 3'd5
  } state_t;

  state_t        state_q;
  logic [17:0]   base_q;
  logic [17:0]   count_q;
  logic [17:0]   idx_q;
  logic [TW-1:0] timer_q;
  logic          busy_q;
  logic          finished_q;
  logic          error_q;
  logic          wr_q;
  logic [17:0]   addr_q;
  logic [7:0]    data_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   fill_q;

  logic pix_ready;
  logic push;
  logic pop;
  logic flush;

  assign pix_ready = busy_q && (fill_q != FIFO_FULL);
  assign push      = wb.pix_valid && pix_ready;
  assign pop       = (state_q == S_FETCH) && (fill_q != '0);
  assign flush     = (state_q == S_ABORT);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wb.pix_data;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      timer_q    <= '0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
      error_q    <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      finished_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q  <= base_addr;
            count_q <= pix_count;
            error_q <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= (pix_count == 18'd0) ? S_DONE : S_FETCH;
          end
        end
        // address/new_data load only here, so they hold for the whole request.
        S_FETCH: begin
          if (fill_q != '0) begin
            data_q  <= mem_q[rd_ptr_q];
            addr_q  <= base_q + idx_q;
            wr_q    <= 1'b1;
            timer_q <= '0;
            state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (wb.wr_done) begin
            wr_q    <= 1'b0;
            state_q <= S_RELEASE;
          end else if (timer_q == TIMER_MAX) begin
            wr_q    <= 1'b0;
            state_q <= S_ABORT;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        // Wait for wr_done to clear so the next request never overlaps the old done.
        S_RELEASE: begin
          if (!wb.wr_done) begin
            idx_q   <= idx_q + 18'd1;
            state_q <= (idx_q + 18'd1 == count_q) ? S_DONE : S_FETCH;
          end
        end
        S_DONE: begin
          finished_q <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        S_ABORT: begin
          error_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wb.pix_ready    = pix_ready;
  assign wb.write_result = wr_q;
  assign wb.address      = addr_q;
  assign wb.new_data     = data_q;
  assign busy            = busy_q;
  assign finished        = finished_q;
  assign error           = error_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_result_writeback.sv
// Directed bench for result_writeback: pixel driver, frame-buffer done model and
// per-scenario tasks comparing captured writes against hand-computed expectations.
module tb_result_writeback;

  logic        clk;
  logic        reset;
  logic        start;
  logic [17:0] base_addr;
  logic [17:0] pix_count;
  logic        busy;
  logic        finished;
  logic        error;
  logic [2:0]  dbg_state;

  result_writeback_if wb ();

  result_writeback #(.FIFO_DEPTH(4), .TIMEOUT(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .pix_count (pix_count),
    .busy      (busy),
    .finished  (finished),
    .error     (error),
    .dbg_state (dbg_state),
    .wb        (wb)
  );

  int checks = 0;
  int errors = 0;

  logic [25:0] exp_q[$];
  logic [25:0] got_q[$];
  logic [7:0]  pix_src_q[$];

  int          done_lat = 5;
  int          done_hold = 1;
  bit          unstable_seen = 0;
  bit          overlap_seen = 0;
  int          fin_count = 0;
  int          wr_rise = 0;
  bit          wr_prev = 0;
  bit          ready_seen = 0;
  logic [17:0] m_addr;
  logic [7:0]  m_data;
  int          m_n;

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pixel driver: presents pix_src_q front, pops it once the beat is accepted.
  initial begin
    wb.pix_valid = 1'b0;
    wb.pix_data  = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (wb.pix_valid && ready_seen && pix_src_q.size() > 0) void'(pix_src_q.pop_front());
      if (pix_src_q.size() > 0) begin
        wb.pix_valid = 1'b1;
        wb.pix_data  = pix_src_q[0];
      end else begin
        wb.pix_valid = 1'b0;
        wb.pix_data  = 8'h00;
      end
      ready_seen = wb.pix_ready;
    end
  end

  // Frame-buffer done model: done_lat cycles of latency (<0 = never), holds done done_hold cycles.
  initial begin
    wb.wr_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (wb.write_result === 1'b1) begin
        m_addr = wb.address;
        m_data = wb.new_data;
        m_n = 0;
        while (wb.write_result === 1'b1 && (done_lat < 0 || m_n < done_lat)) begin
          @(posedge clk); #1;
          m_n++;
          if (wb.write_result === 1'b1 && (wb.address !== m_addr || wb.new_data !== m_data))
            unstable_seen = 1'b1;
        end
        if (wb.write_result === 1'b1) begin
          wb.wr_done = 1'b1;
          got_q.push_back({m_addr, m_data});
          m_n = 0;
          while (wb.write_result === 1'b1 && m_n < 8) begin
            @(posedge clk); #1;
            m_n++;
          end
          for (int k = 0; k < done_hold; k++) begin
            @(posedge clk); #1;
            if (wb.write_result === 1'b1) overlap_seen = 1'b1;
          end
          wb.wr_done = 1'b0;
        end
      end
    end
  end

  // Event monitor
  initial begin
    forever begin
      @(posedge clk); #1;
      if (finished === 1'b1) fin_count++;
      if (wb.write_result === 1'b1 && !wr_prev) wr_rise++;
      wr_prev = (wb.write_result === 1'b1);
    end
  end

  task automatic start_job(input logic [17:0] b, input logic [17:0] c);
    start = 1'b1;
    base_addr = b;
    pix_count = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clk); #1;
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_scoreboard();
    exp_q.delete();
    got_q.delete();
    unstable_seen = 1'b0;
    overlap_seen = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (wb.write_result !== 1'b0) begin errors++; $display("FAIL reset_write_result: got %b expected 0", wb.write_result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (wb.address !== 18'h0) begin errors++; $display("FAIL reset_address: got %h expected 00000", wb.address); end
    checks++; if ({finished, error, wb.pix_ready} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {finished, error, wb.pix_ready}); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
  endtask

  task automatic test_basic();
    bit ok;
    int fin0;
    clear_scoreboard();
    done_lat = 5;
    done_hold = 2;
    fin0 = fin_count;
    pix_src_q.push_back(8'h11); pix_src_q.push_back(8'h22);
    pix_src_q.push_back(8'h33); pix_src_q.push_back(8'h44);
    exp_q.push_back({18'h00100, 8'h11}); exp_q.push_back({18'h00101, 8'h22});
    exp_q.push_back({18'h00102, 8'h33}); exp_q.push_back({18'h00103, 8'h44});
    start_job(18'h00100, 18'd4);
    wait_idle(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: busy still %b after 400 cycles, expected 0", busy); end
    repeat (3) @(posedge clk); #1;
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL basic_count: got %0d writes expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_write%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
    checks++; if (fin_count - fin0 !== 1) begin errors++; $display("FAIL basic_finished: got %0d pulses expected 1", fin_count - fin0); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL basic_error: got %b expected 0", error); end
    checks++; if (unstable_seen !== 1'b0) begin errors++; $display("FAIL basic_stable: got %b expected 0", unstable_seen); end
    checks++; if (overlap_seen !== 1'b0) begin errors++; $display("FAIL basic_overlap: got %b expected 0", overlap_seen); end
    done_hold = 1;
  endtask

  task automatic test_zero_count();
    int wr0;
    wr0 = wr_rise;
    start_job(18'h00123, 18'd0);
    checks++; if ({busy, finished} !== 2'b10) begin errors++; $display("FAIL zero_cycle1: got busy,finished=%b expected 10", {busy, finished}); end
    @(posedge clk); #1;
    checks++; if ({busy, finished} !== 2'b01) begin errors++; $display("FAIL zero_cycle2: got busy,finished=%b expected 01", {busy, finished}); end
    @(posedge clk); #1;
    checks++; if (finished !== 1'b0) begin errors++; $display("FAIL zero_cycle3: got finished=%b expected 0", finished); end
    checks++; if (wr_rise !== wr0) begin errors++; $display("FAIL zero_no_write: got %0d requests expected 0", wr_rise - wr0); end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_scoreboard();
    done_lat = 20;
    for (int i = 0; i < 8; i++) begin
      pix_src_q.push_back(8'hA0 + 8'(i));
      exp_q.push_back({18'h00400 + 18'(i), 8'hA0 + 8'(i)});
    end
    start_job(18'h00400, 18'd8);
    repeat (8) @(posedge clk); #1;
    checks++; if (wb.pix_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b expected 0", wb.pix_ready); end
    checks++; if (pix_src_q.size() !== 3) begin errors++; $display("FAIL bp_accepted: got %0d pending expected 3", pix_src_q.size()); end
    wait_idle(800, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: busy still %b after 800 cycles, expected 0", busy); end
    repeat (3) @(posedge clk); #1;
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d writes expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_write%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
    checks++; if (unstable_seen !== 1'b0) begin errors++; $display("FAIL bp_stable: got %b expected 0", unstable_seen); end
  endtask

  task automatic test_timeout();
    bit ok;
    int fin0;
    int n;
    clear_scoreboard();
    done_lat = -1;
    fin0 = fin_count;
    pix_src_q.push_back(8'h77);
    start_job(18'h00010, 18'd2);
    n = 0;
    while (wb.write_result !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (wb.write_result !== 1'b1) begin errors++; $display("FAIL to_request: got write_result %b expected 1", wb.write_result); end
    n = 0;
    while (wb.write_result === 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (n !== 64) begin errors++; $display("FAIL to_length: got %0d cycles expected 64", n); end
    @(posedge clk); #1;
    checks++; if ({error, busy} !== 2'b10) begin errors++; $display("FAIL to_flags: got error,busy=%b expected 10", {error, busy}); end
    repeat (2) @(posedge clk); #1;
    checks++; if (fin_count !== fin0) begin errors++; $display("FAIL to_no_finish: got %0d pulses expected 0", fin_count - fin0); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", error); end
    done_lat = 3;
    start_job(18'h00000, 18'd0);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL to_clear: got %b expected 0", error); end
    wait_idle(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_restart: busy still %b, expected 0", busy); end
  endtask

  task automatic test_wrap();
    bit ok;
    clear_scoreboard();
    done_lat = 1;
    pix_src_q.push_back(8'hB1); pix_src_q.push_back(8'hB2); pix_src_q.push_back(8'hB3);
    exp_q.push_back({18'h3FFFE, 8'hB1}); exp_q.push_back({18'h3FFFF, 8'hB2});
    exp_q.push_back({18'h00000, 8'hB3});
    start_job(18'h3FFFE, 18'd3);
    wait_idle(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout: busy still %b, expected 0", busy); end
    repeat (3) @(posedge clk); #1;
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL wrap_count: got %0d writes expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_write%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    int fin0;
    int n;
    clear_scoreboard();
    done_lat = -1;
    pix_src_q.push_back(8'h5A);
    start_job(18'h00055, 18'd2);
    n = 0;
    while (wb.write_result !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (wb.write_result !== 1'b1) begin errors++; $display("FAIL rst_request: got write_result %b expected 1", wb.write_result); end
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if ({wb.write_result, busy} !== 2'b00) begin errors++; $display("FAIL rst_async: got write_result,busy=%b expected 00", {wb.write_result, busy}); end
    checks++; if (wb.address !== 18'h0) begin errors++; $display("FAIL rst_address: got %h expected 00000", wb.address); end
    @(posedge clk); #1;
    pix_src_q.delete();
    reset = 1'b0;
    @(posedge clk); #1;
    clear_scoreboard();
    done_lat = 2;
    fin0 = fin_count;
    pix_src_q.push_back(8'h61); pix_src_q.push_back(8'h62);
    exp_q.push_back({18'h00200, 8'h61}); exp_q.push_back({18'h00201, 8'h62});
    start_job(18'h00200, 18'd2);
    repeat (3) @(posedge clk); #1;
    start_job(18'h00300, 18'd0);
    wait_idle(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_job_timeout: busy still %b, expected 0", busy); end
    repeat (3) @(posedge clk); #1;
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rst_count: got %0d writes expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rst_write%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
    checks++; if (fin_count - fin0 !== 1) begin errors++; $display("FAIL rst_finished: got %0d pulses expected 1", fin_count - fin0); end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    base_addr = 18'h0;
    pix_count = 18'h0;
    repeat (3) @(posedge clk); #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_basic();
    test_zero_count();
    test_backpressure();
    test_timeout();
    test_wrap();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
